// File: rtl/addr_stream_reader_if.sv
// Stream/memory bundle between the address generator, the read memory and the
// downstream datapath, as seen by addr_stream_reader.
interface addr_stream_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic              run;
  logic              gen_done;
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W:0]   count;
  logic              done;

  // master: the reader itself
  modport master (
    input  run, gen_done, addr_valid, addr, mem_rdata, data_ready,
    output addr_ready, mem_en, mem_addr, data_valid, data, count, done
  );

  // slave: generator, memory and downstream consumer around the reader
  modport slave (
    output run, gen_done, addr_valid, addr, mem_rdata, data_ready,
    input  addr_ready, mem_en, mem_addr, data_valid, data, count, done
  );
endinterface

// File: rtl/addr_stream_reader.sv
// Address-stream consumer: turns accepted addresses into 1-cycle-latency memory
// reads and hands the returned words downstream through a 2-entry buffer.
module addr_stream_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  addr_stream_reader_if.master bus
);

  logic [1:0]              occ_q, occ_d, occ_next;
  logic                    inflight_q, inflight_d;
  logic [ADDR_W:0]         count_q, count_d;
  logic                    seen_q, seen_d;
  logic                    done_q, done_d;
  logic                    pop, push, accept, addr_ready;
  logic [1:0]              wr_slot;
  logic [1:0][DATA_W-1:0]  fifo_flat;

  always_comb begin
    pop        = (occ_q != 2'd0) && bus.data_ready;
    push       = inflight_q;
    // Reads in flight reserve a slot, so the buffer can never overflow.
    addr_ready = !bus.run && (((occ_q + {1'b0, inflight_q}) < 2'd2) || pop);
    accept     = bus.addr_valid && addr_ready;
    wr_slot    = occ_q - {1'b0, pop};
    occ_next   = occ_q + {1'b0, push} - {1'b0, pop};

    occ_d      = occ_next;
    inflight_d = accept;
    count_d    = count_q;
    if (pop && (count_q != '1)) begin
      count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
    end
    seen_d = seen_q | bus.gen_done;
    // Judged on the post-edge state, so done rises as the last word leaves.
    done_d = done_q | ((seen_q | bus.gen_done) && (occ_next == 2'd0) && !accept);

    if (bus.run) begin
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      count_d    = '0;
      seen_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      seen_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      seen_q     <= seen_d;
      done_q     <= done_d;
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down and the returning
  // word lands in the first free slot after that shift.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_q, entry_d;

      always_comb begin
        entry_d = entry_q;
        if (pop) begin
          entry_d = (gi == 0) ? fifo_flat[1] : entry_q;
        end
        if (push && (wr_slot == 2'(gi))) begin
          entry_d = bus.mem_rdata;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign fifo_flat[gi] = entry_q;
    end
  endgenerate

  assign bus.addr_ready = addr_ready;
  assign bus.mem_en     = accept;
  assign bus.mem_addr   = bus.addr;
  assign bus.data_valid = (occ_q != 2'd0);
  assign bus.data       = fifo_flat[0];
  assign bus.count      = count_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_addr_stream_reader.sv
// Bench for addr_stream_reader: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_addr_stream_reader;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int CNT_MAX = (1 << (ADDR_W + 1)) - 1;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 0;

  addr_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  addr_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // memory model: mem[a] = 3*a, one cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= DATA_W'(3 * int'(bus.mem_addr));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  int mq[$];
  bit m_infl;
  int m_infl_word;
  int m_count;
  bit m_seen;
  bit m_done;

  always @(negedge clk) begin : model_blk
    int sz;
    bit pop_e, ar_e, acc_e, seen_now;
    if (chk_en) begin
      sz    = mq.size();
      pop_e = (sz != 0) && (bus.data_ready == 1'b1);
      ar_e  = (bus.run == 1'b0) && (((sz + int'(m_infl)) < 2) || pop_e);
      acc_e = (bus.addr_valid == 1'b1) && ar_e;
      chk("m_data_valid", 64'(bus.data_valid), 64'(sz != 0));
      if (sz != 0) chk("m_data", 64'(bus.data), 64'(mq[0]));
      chk("m_addr_ready", 64'(bus.addr_ready), 64'(ar_e));
      chk("m_mem_en", 64'(bus.mem_en), 64'(acc_e));
      if (acc_e) chk("m_mem_addr", 64'(bus.mem_addr), 64'(bus.addr));
      chk("m_count", 64'(bus.count), 64'(m_count));
      chk("m_done", 64'(bus.done), 64'(m_done));
      chk("occ_bound", 64'((int'(dut.occ_q) + int'(dut.inflight_q)) <= 2), 64'(1));
      chk("model_bound", 64'((sz + int'(m_infl)) <= 2), 64'(1));
      if (rst || bus.run) begin
        mq.delete();
        m_infl  = 0;
        m_count = 0;
        m_seen  = 0;
        m_done  = 0;
      end else begin
        if (pop_e) begin
          void'(mq.pop_front());
          if (m_count < CNT_MAX) m_count++;
        end
        if (m_infl) mq.push_back(m_infl_word);
        m_infl      = acc_e;
        m_infl_word = 3 * int'(bus.addr);
        seen_now    = m_seen || (bus.gen_done == 1'b1);
        m_seen      = seen_now;
        if (seen_now && mq.size() == 0 && !m_infl) m_done = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, acc;
    int got[$];
    rst = 1; bus.run = 0; bus.gen_done = 0; bus.addr_valid = 0; bus.addr = '0;
    bus.data_ready = 1; bus.mem_rdata = '0;
    m_infl = 0; m_count = 0; m_seen = 0; m_done = 0; m_infl_word = 0;
    step();
    chk_en = 1;
    step(); step();
    rst = 0;
    @(negedge clk);
    chk("rst_data_valid", 64'(bus.data_valid), 64'(0));
    chk("rst_addr_ready", 64'(bus.addr_ready), 64'(1));
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    $display("txn reset released");

    // basic stream 4..7 at full rate
    step(); bus.run = 1;
    step(); bus.run = 0; bus.addr_valid = 1; bus.addr = 4'd4;
    step(); bus.addr = 4'd5;
    @(negedge clk); chk("t1_lat_empty", 64'(bus.data_valid), 64'(0));
    step(); bus.addr = 4'd6;
    @(negedge clk); chk("t1_d0", 64'(bus.data), 64'(12));
    step(); bus.addr = 4'd7;
    @(negedge clk); chk("t1_d1", 64'(bus.data), 64'(15));
    step(); bus.addr_valid = 0;
    @(negedge clk); chk("t1_d2", 64'(bus.data), 64'(18));
    step(); bus.gen_done = 1;
    @(negedge clk); chk("t1_d3", 64'(bus.data), 64'(21)); chk("t1_done_early", 64'(bus.done), 64'(0));
    step(); bus.gen_done = 0;
    @(negedge clk);
    chk("t1_done", 64'(bus.done), 64'(1));
    chk("t1_count", 64'(bus.count), 64'(4));
    $display("txn stream 4..7 count=%0d done=%0d", bus.count, bus.done);

    // backpressure: 2 accepts then stall, then drain in order
    step(); bus.run = 1; bus.data_ready = 0;
    step(); bus.run = 0; bus.addr_valid = 1; a = 8; bus.addr = 4'(a); acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.addr_ready) begin acc++; a++; end
      step(); bus.addr = 4'(a);
    end
    @(negedge clk);
    chk("t2_accepts", 64'(acc), 64'(2));
    chk("t2_stall", 64'(bus.addr_ready), 64'(0));
    chk("t2_hold", 64'(bus.data), 64'(24));
    step(); bus.data_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.data_valid) got.push_back(int'(bus.data));
      if (bus.addr_valid && bus.addr_ready) a++;
      step();
      if (a > 10) bus.addr_valid = 0; else bus.addr = 4'(a);
    end
    chk("t2_n", 64'(got.size()), 64'(3));
    if (got.size() == 3) begin
      chk("t2_w0", 64'(got[0]), 64'(24));
      chk("t2_w1", 64'(got[1]), 64'(27));
      chk("t2_w2", 64'(got[2]), 64'(30));
    end
    $display("txn backpressure words=%0d", got.size());

    // empty transfer
    bus.run = 1;
    @(negedge clk); chk("t3_mem_en0", 64'(bus.mem_en), 64'(0));
    step(); bus.run = 0; bus.gen_done = 1;
    @(negedge clk); chk("t3_done0", 64'(bus.done), 64'(0)); chk("t3_mem_en1", 64'(bus.mem_en), 64'(0));
    step(); bus.gen_done = 0;
    @(negedge clk);
    chk("t3_done", 64'(bus.done), 64'(1));
    chk("t3_count", 64'(bus.count), 64'(0));
    $display("txn empty transfer done=%0d", bus.done);

    // steady state occ=1 inflight=1
    step(); bus.run = 1; bus.data_ready = 1;
    step(); bus.run = 0; bus.addr_valid = 1; bus.addr = 4'd1;
    step(); bus.addr = 4'd2;
    step(); bus.addr = 4'd3;
    @(negedge clk); chk("t4_full_rate", 64'(bus.addr_ready), 64'(1));
    step(); bus.addr = 4'd4; bus.data_ready = 0;
    @(negedge clk); chk("t4_bp_ready", 64'(bus.addr_ready), 64'(0)); chk("t4_bp_data", 64'(bus.data), 64'(6));
    step(); bus.data_ready = 1;
    @(negedge clk); chk("t4_pop_ready", 64'(bus.addr_ready), 64'(1));
    $display("txn steady-state throughput");

    // run with a full buffer and a read in flight
    step(); bus.addr_valid = 0; bus.data_ready = 0; bus.run = 1;
    step(); bus.run = 0;
    @(negedge clk);
    chk("t5_valid", 64'(bus.data_valid), 64'(0));
    chk("t5_count", 64'(bus.count), 64'(0));
    chk("t5_done", 64'(bus.done), 64'(0));
    step();
    @(negedge clk); chk("t5_stale", 64'(bus.data_valid), 64'(0));
    step(); bus.addr_valid = 1; bus.addr = 4'd2; bus.data_ready = 1;
    step(); bus.addr = 4'd3;
    step(); bus.addr_valid = 0;
    @(negedge clk); chk("t5_new0", 64'(bus.data), 64'(6));
    step(); bus.gen_done = 1;
    @(negedge clk); chk("t5_new1", 64'(bus.data), 64'(9));
    step(); bus.gen_done = 0;
    @(negedge clk); chk("t5_done_new", 64'(bus.done), 64'(1)); chk("t5_count_new", 64'(bus.count), 64'(2));
    $display("txn run mid-stream then new stream");

    // address after done, then synchronous reset
    step(); bus.addr_valid = 1; bus.addr = 4'd5; bus.data_ready = 0;
    @(negedge clk); chk("t6_late_accept", 64'(bus.addr_ready), 64'(1));
    step(); bus.addr_valid = 0;
    step();
    @(negedge clk); chk("t6_late_data", 64'(bus.data), 64'(15)); chk("t6_done_held", 64'(bus.done), 64'(1));
    step(); rst = 1;
    @(negedge clk);
    chk("t6_sync_done", 64'(bus.done), 64'(1));
    chk("t6_sync_valid", 64'(bus.data_valid), 64'(1));
    step(); rst = 0;
    @(negedge clk);
    chk("t6_rst_valid", 64'(bus.data_valid), 64'(0));
    chk("t6_rst_done", 64'(bus.done), 64'(0));
    chk("t6_rst_count", 64'(bus.count), 64'(0));
    chk("t6_rst_ready", 64'(bus.addr_ready), 64'(1));
    chk("t6_rst_mem_en", 64'(bus.mem_en), 64'(0));
    $display("txn synchronous reset");

    // count saturation
    step(); bus.run = 1; bus.data_ready = 1;
    step(); bus.run = 0; bus.addr_valid = 1;
    for (int i = 0; i < 34; i++) begin
      bus.addr = 4'(i % 16);
      step();
    end
    bus.addr_valid = 0;
    step(); step(); step();
    @(negedge clk); chk("t7_saturate", 64'(bus.count), 64'(CNT_MAX));
    $display("txn count saturation count=%0d", bus.count);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
